// File: rtl/updown10.sv
// updown10: single-digit decimal (0-9) up/down counter.
// A free-running prescaler divides CLK by SEC1_MAX to produce a one-cycle step
// enable; on every enable edge the BCD digit moves one place up or down,
// wrapping 9<->0. COUNT comes straight from a register, so it is glitch-free
// and has no combinational path from DEC.
module updown10 #(
  parameter int unsigned SEC1_MAX = 125_000_000  // CLK cycles per step, >= 1
) (
  input  logic       CLK,    // system clock, rising edge
  input  logic       RESET,  // asynchronous, active-low
  input  logic       DEC,    // 1 = count down, 0 = count up
  output logic [3:0] COUNT   // current BCD digit, 0..9
);

  // Prescaler needs to hold 0..SEC1_MAX-1; a divide-by-1 still gets one bit so
  // the register and compare stay well-formed.
  localparam int unsigned PRE_W = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SEC1_MAX - 1);

  localparam logic [3:0] DIGIT_MIN = 4'd0;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  logic [PRE_W-1:0] prescaler;
  logic             step_en;
  logic [3:0]       count_next;

  // Enable is decoded from the terminal prescaler value; with SEC1_MAX==1 the
  // prescaler sits at 0 == PRE_LAST and the enable is high every cycle.
  assign step_en = (prescaler == PRE_LAST);

  // Free-running prescaler: 0..SEC1_MAX-1 then wrap; DEC never restarts it.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!RESET) begin
      prescaler <= '0;
    end else if (step_en) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Next digit for an enable edge: step in the sampled direction with wrap;
  // any out-of-range value recovers to 0.
  always_comb begin
    // NOTE: default assigned first so every path drives count_next and no
    // latch is inferred.
    count_next = DIGIT_MIN;
    if (COUNT > DIGIT_MAX) begin
      count_next = DIGIT_MIN;
    end else if (DEC) begin
      count_next = (COUNT == DIGIT_MIN) ? DIGIT_MAX : COUNT - 4'd1;
    end else begin
      count_next = (COUNT == DIGIT_MAX) ? DIGIT_MIN : COUNT + 4'd1;
    end
  end

  // Digit register: loads only on enable edges, holds otherwise; DEC is thus
  // sampled solely on the enable edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      COUNT <= DIGIT_MIN;
    end else if (step_en) begin
      COUNT <= count_next;
    end
  end

endmodule

// File: tb/tb_updown10.sv
// Directed self-checking bench for updown10: a SEC1_MAX=4 instance exercises
// reset, down/up counting with wrap, DEC glitches between enables and
// mid-count reset; a SEC1_MAX=1 instance checks the every-edge case.
module tb_updown10;

  logic       clk;
  logic       rst_n;
  logic       dec;
  logic [3:0] count;

  logic       rst1_n;
  logic       dec1;
  logic [3:0] count1;

  int asserts  = 0;
  int failures = 0;

  // Reference state for the SEC1_MAX=4 instance, advanced once per edge.
  int m_pre = 0;
  int m_cnt = 0;

  updown10 #(.SEC1_MAX(4)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .DEC   (dec),
    .COUNT (count)
  );

  updown10 #(.SEC1_MAX(1)) dut1 (
    .CLK   (clk),
    .RESET (rst1_n),
    .DEC   (dec1),
    .COUNT (count1)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Advance one rising edge, update the reference, then settle #1 past it.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (m_pre == 3) begin
        m_pre = 0;
        if (dec) m_cnt = (m_cnt == 0) ? 9 : m_cnt - 1;
        else     m_cnt = (m_cnt == 9) ? 0 : m_cnt + 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    dec    = 1'b0;
    dec1   = 1'b0;
    #10;
    asserts++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL reset_async_initial: count=%0d expected 0", count);
    end
    tick();
    asserts++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL reset_held: count=%0d expected 0", count);
    end
    asserts++;
    if (count1 !== 4'd0) begin
      failures++;
      $display("FAIL reset_held_fast: count1=%0d expected 0", count1);
    end
  endtask

  // Release with DEC=1: 0 for 3 edges, 9 on edge 4, then 15 steps in 60 edges.
  task automatic test_count_down();
    rst_n = 1'b1;
    dec   = 1'b1;
    m_pre = 0;
    m_cnt = 0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      asserts++;
      if (count !== 4'd0) begin
        failures++;
        $display("FAIL down_first_wait edge %0d: count=%0d expected 0", e, count);
      end
    end
    tick();
    asserts++;
    if (count !== 4'd9) begin
      failures++;
      $display("FAIL down_first_step_wrap: count=%0d expected 9", count);
    end
    for (int e = 5; e <= 60; e++) begin
      tick();
      asserts++;
      if (count !== 4'(m_cnt)) begin
        failures++;
        $display("FAIL down_run edge %0d: count=%0d expected %0d", e, count, m_cnt);
      end
    end
    asserts++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL down_after_60: count=%0d expected 5", count);
    end
  endtask

  // DEC=0 for 40 edges: 6,7,8,9,0,...,5 with the 9->0 wrap observed.
  task automatic test_count_up();
    bit saw_wrap = 1'b0;
    logic [3:0] prev;
    dec  = 1'b0;
    prev = count;
    for (int e = 1; e <= 40; e++) begin
      tick();
      asserts++;
      if (count !== 4'(m_cnt)) begin
        failures++;
        $display("FAIL up_run edge %0d: count=%0d expected %0d", e, count, m_cnt);
      end
      if (prev == 4'd9 && count == 4'd0) saw_wrap = 1'b1;
      prev = count;
    end
    asserts++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL up_after_40: count=%0d expected 5", count);
    end
    asserts++;
    if (saw_wrap !== 1'b1) begin
      failures++;
      $display("FAIL up_wrap_9_to_0: seen=%0b expected 1", saw_wrap);
    end
  endtask

  // Prescaler is at 0 here. Pulse DEC high after edges 1..2 only; edge 4 is the
  // enable and must step up 5->6 with no extra step before it.
  task automatic test_dec_glitch();
    tick();            // prescaler 1
    dec = 1'b1;
    tick();            // prescaler 2
    asserts++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL glitch_hold_a: count=%0d expected 5", count);
    end
    tick();            // prescaler 3
    dec = 1'b0;
    asserts++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL glitch_hold_b: count=%0d expected 5", count);
    end
    tick();            // enable edge
    asserts++;
    if (count !== 4'd6) begin
      failures++;
      $display("FAIL glitch_step_dir: count=%0d expected 6", count);
    end
  endtask

  // Reach COUNT=7 with prescaler=2, reset between edges, then release.
  task automatic test_mid_reset();
    for (int e = 1; e <= 6; e++) tick();
    asserts++;
    if (count !== 4'd7) begin
      failures++;
      $display("FAIL mid_pre_reset_value: count=%0d expected 7", count);
    end
    rst_n = 1'b0;
    #1;
    asserts++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL mid_async_clear: count=%0d expected 0", count);
    end
    tick();
    rst_n = 1'b1;
    m_pre = 0;
    m_cnt = 0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      asserts++;
      if (count !== 4'd0) begin
        failures++;
        $display("FAIL mid_release_wait edge %0d: count=%0d expected 0", e, count);
      end
    end
    tick();
    asserts++;
    if (count !== 4'd1) begin
      failures++;
      $display("FAIL mid_release_step: count=%0d expected 1", count);
    end
  endtask

  // SEC1_MAX=1: counts up on every edge, wrapping 9->0.
  task automatic test_fast_rate();
    logic [3:0] exp_cnt;
    rst1_n  = 1'b1;
    dec1    = 1'b0;
    exp_cnt = 4'd0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      exp_cnt = (exp_cnt == 4'd9) ? 4'd0 : exp_cnt + 4'd1;
      asserts++;
      if (count1 !== exp_cnt) begin
        failures++;
        $display("FAIL fast_step edge %0d: count1=%0d expected %0d", e, count1, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_down();
    test_count_up();
    test_dec_glitch();
    test_mid_reset();
    test_fast_rate();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
